pll_lock_monitor: RTL and testbench
===================================

# pll_lock_monitor

Frequency-checking lock monitor for the generated fabric clock. It samples a divided toggle from the PLL output domain in the `clk_in` (reference, 100 MHz) domain and counts toggle edges over fixed windows. It declares lock only after a run of in-range windows and drives a synchronous reset for downstream matrix-driver logic until lock is established. It replaces reliance on the PLL primitive's LOCKED pin with an independent, measured frequency check.

## Interface
Parameters:
- `WINDOW`, 1024 — `clk_in` cycles per measurement window (≥ 16).
- `CNT_W`, 16 — width of the edge accumulator and `edge_count`.
- `EXP_MIN`, 120 — minimum edges per window counted as good (inclusive).
- `EXP_MAX`, 136 — maximum edges per window counted as good (inclusive).
- `LOCK_WINDOWS`, 4 — consecutive good windows required to assert lock (≥ 1).

Ports:
- `clk_in` — input, 1 — reference clock; the only clock.
- `reset` — input, 1 — synchronous, active-high reset.
- `tog_async` — input, 1 — toggle from the generated-clock domain (flips every 64 output clocks); asynchronous to `clk_in`.
- `locked` — output, 1 — measured frequency in range.
- `rst_out` — output, 1 — synchronous active-high reset for downstream logic; equals `!locked`.
- `edge_count` — output, CNT_W — edge total of the last completed window.
- `window_done` — output, 1 — one-cycle pulse when `edge_count` updates.
- `fault_sticky` — output, 1 — latched loss-of-lock (see Configuration).

## Operation
- **Synchronizer and edge detect:** `tog_async` passes through a 2-flop synchronizer, then a third flop. An edge is `s2 ^ s3`, so both rising and falling transitions count. All three flops reset to 0.
- **Window counter:** `win_cnt` runs 0..WINDOW-1 and wraps. In the cycle where `win_cnt == WINDOW-1`:
  - `sum = edge_acc + edge_det`, computed with saturation.
  - `edge_count <= sum`, `edge_acc <= 0`, and `window_done` pulses.
  - The window is good iff `EXP_MIN ≤ sum ≤ EXP_MAX`.
- **Accumulator:** in all other cycles, `edge_acc` increments on `edge_det`. It saturates at 2^CNT_W−1 and never wraps.
- **FSM states:**
  - **FLUSH:** entered on reset. The first window result is published but ignored for lock decisions. At window end, go to ACQUIRE with `good_run = 0`.
  - **ACQUIRE:**
    - Good window: `good_run++`.
    - Bad window: `good_run <= 0`.
    - When `good_run` would reach LOCK_WINDOWS, go to LOCKED and set `locked <= 1` on that same edge.
  - **LOCKED:**
    - Good window: stay in LOCKED.
    - Bad window: go to ACQUIRE, clear `good_run`, set `locked <= 0`, and set the fault latch.
- **Outputs:** `locked` and `rst_out` are registered and always complementary. There is no cycle in which both are 1 or both are 0.
- **Reset taken anywhere** (including mid-window or while LOCKED) restores all state next edge: FSM in FLUSH, counters 0, synchronizer flops 0.

## Timing
- Reset values: `locked` 0, `rst_out` 1, `edge_count` 0, `window_done` 0, `fault_sticky` 0.
- After `reset` deasserts, the first `window_done` occurs WINDOW cycles later.
- Best-case lock is (1 + LOCK_WINDOWS) × WINDOW cycles after reset release: 5120 cycles with the defaults.
- Edge-to-count latency is 3 cycles (2 synchronizer stages plus the edge flop). An edge arriving in a window's last 3 cycles counts in the next window.
- Lock loss is detected only at a window boundary. Worst-case detection delay is WINDOW + 3 cycles.
- `locked`, `rst_out`, `edge_count`, and `window_done` all update on the same clock edge.

## Configuration
- Macro: `PLL_LOCK_MON_STICKY_FAULT_EN`.
- **Defined:** `fault_sticky` sets on any LOCKED→ACQUIRE transition and holds until `reset`. Relock does not clear it.
- **Not defined:** the fault latch is not built and `fault_sticky` is tied to 0.
- The port list is the same in both builds.

## Test plan
1. **Nominal lock:** reset, then `tog_async` flips every 8 cycles → `edge_count` = 128 (±1) at each `window_done`. `locked` rises and `rst_out` falls on the same edge, 5120 cycles after reset release (±3).
2. **Slow clock:** flips every 10 cycles (102–103 edges) → `locked` stays 0 for 20 windows and `rst_out` stays 1.
3. **Loss of lock:** lock as in test 1, then hold `tog_async` constant → at the next window end `edge_count` < 120, `locked` = 0, `rst_out` = 1. `fault_sticky` = 1 only with the macro defined. Then restore toggling → relock after 4 good windows, and `fault_sticky` stays 1 (macro builds).
4. **Range boundaries:** inject exactly 120 edges and exactly 136 → good. Inject 119 or 137 during ACQUIRE → `good_run` resets, so lock needs 4 further good windows.
5. **Reset mid-operation:** pulse `reset` for 1 cycle during the third ACQUIRE window → all outputs return to reset values next edge. Lock then requires a full 5 windows again.
6. **Saturation:** set `CNT_W` = 4 with toggling every 2 cycles → `edge_count` = 15 with no wrap. The window is bad, so there is no lock.

Source files
------------

// File: rtl/pll_lock_monitor.sv
// pll_lock_monitor: measured-frequency lock detector for the generated fabric clock.
// Counts edges of a divided toggle from the PLL domain over fixed clk_in windows and
// declares lock after LOCK_WINDOWS consecutive in-range windows. rst_out = !locked.
// Optional build macro: PLL_LOCK_MON_STICKY_FAULT_EN (latched loss-of-lock flag).
module pll_lock_monitor #(
    parameter int WINDOW       = 1024,
    parameter int CNT_W        = 16,
    parameter int EXP_MIN      = 120,
    parameter int EXP_MAX      = 136,
    parameter int LOCK_WINDOWS = 4
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             tog_async,
    output logic             locked,
    output logic             rst_out,
    output logic [CNT_W-1:0] edge_count,
    output logic             window_done,
    output logic             fault_sticky
);
    localparam int               WIN_W    = $clog2(WINDOW);
    localparam int               RUN_W    = $clog2(LOCK_WINDOWS + 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [RUN_W-1:0] RUN_PRE  = RUN_W'(LOCK_WINDOWS - 1);
    localparam logic [CNT_W-1:0] SAT      = '1;
    localparam logic [31:0]      MIN_U    = 32'(EXP_MIN);
    localparam logic [31:0]      MAX_U    = 32'(EXP_MAX);

    typedef enum logic [1:0] {
        S_FLUSH,
        S_ACQUIRE,
        S_LOCKED
    } state_t;

    logic             r_s1, r_s2, r_s3;
    logic [WIN_W-1:0] r_win_cnt;
    logic [CNT_W-1:0] r_edge_acc;
    logic [CNT_W-1:0] r_edge_count;
    logic             r_window_done;
    state_t           r_state, w_state_nxt;
    logic [RUN_W-1:0] r_good_run, w_run_nxt;
    logic             r_locked, w_locked_nxt;
    logic             r_rst_out;

    logic             w_edge;
    logic             w_win_end;
    logic [CNT_W-1:0] w_sum;
    logic [31:0]      w_sum32;
    logic             w_good;

    // Two-flop synchronizer plus an edge flop; both toggle directions count.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= tog_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_edge    = r_s2 ^ r_s3;
    assign w_win_end = (r_win_cnt == WIN_LAST);
    // Edge seen in the window's last cycle is folded into that window's total.
    assign w_sum     = (r_edge_acc == SAT) ? SAT : r_edge_acc + CNT_W'(w_edge);
    assign w_sum32   = 32'(w_sum);
    assign w_good    = (w_sum32 >= MIN_U) && (w_sum32 <= MAX_U);

    // Window counter and saturating edge accumulator; publish total at window end.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_win_cnt     <= '0;
            r_edge_acc    <= '0;
            r_edge_count  <= '0;
            r_window_done <= 1'b0;
        end else begin
            r_window_done <= w_win_end;
            if (w_win_end) begin
                r_win_cnt    <= '0;
                r_edge_acc   <= '0;
                r_edge_count <= w_sum;
            end else begin
                r_win_cnt  <= r_win_cnt + WIN_W'(1);
                r_edge_acc <= w_sum;
            end
        end
    end

    // FSM state register with the lock/reset outputs it owns.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state    <= S_FLUSH;
            r_good_run <= '0;
            r_locked   <= 1'b0;
            r_rst_out  <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_good_run <= w_run_nxt;
            r_locked   <= w_locked_nxt;
            r_rst_out  <= ~w_locked_nxt;
        end
    end

    // Next-state logic: decisions are taken only at window boundaries.
    always_comb begin
        w_state_nxt  = r_state;
        w_run_nxt    = r_good_run;
        w_locked_nxt = r_locked;
        if (w_win_end) begin
            case (r_state)
                S_FLUSH: begin
                    // First window straddles reset release; its count is not trusted.
                    w_state_nxt = S_ACQUIRE;
                    w_run_nxt   = '0;
                end
                S_ACQUIRE: begin
                    if (!w_good) begin
                        w_run_nxt = '0;
                    end else if (r_good_run == RUN_PRE) begin
                        w_state_nxt  = S_LOCKED;
                        w_run_nxt    = '0;
                        w_locked_nxt = 1'b1;
                    end else begin
                        w_run_nxt = r_good_run + RUN_W'(1);
                    end
                end
                S_LOCKED: begin
                    if (!w_good) begin
                        w_state_nxt  = S_ACQUIRE;
                        w_run_nxt    = '0;
                        w_locked_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt  = S_FLUSH;
                    w_run_nxt    = '0;
                    w_locked_nxt = 1'b0;
                end
            endcase
        end
    end

`ifdef PLL_LOCK_MON_STICKY_FAULT_EN
    logic r_fault;
    logic w_loss;

    assign w_loss = (r_state == S_LOCKED) && w_win_end && !w_good;

    // Loss-of-lock latch; only reset clears it, relock does not.
    always_ff @(posedge clk_in) begin
        if (reset) r_fault <= 1'b0;
        else if (w_loss) r_fault <= 1'b1;
    end

    assign fault_sticky = r_fault;
`else
    assign fault_sticky = 1'b0;
`endif

    assign locked      = r_locked;
    assign rst_out     = r_rst_out;
    assign edge_count  = r_edge_count;
    assign window_done = r_window_done;
endmodule

// File: tb/tb_pll_lock_monitor.sv
// Directed bench for pll_lock_monitor: nominal lock, loss/relock, slow clock,
// range boundaries, mid-window reset and accumulator saturation (CNT_W=4 instance).
module tb_pll_lock_monitor;
    logic        clk = 1'b0;
    logic        reset;
    logic        tog, tog_b;
    logic        locked, rst_out, window_done, fault_sticky;
    logic [15:0] edge_count;
    logic        locked_b, rst_out_b, window_done_b, fault_sticky_b;
    logic [3:0]  edge_count_b;

`ifdef PLL_LOCK_MON_STICKY_FAULT_EN
    localparam logic [31:0] FAULT_EXP = 32'd1;
`else
    localparam logic [31:0] FAULT_EXP = 32'd0;
`endif

    int n_chk = 0, n_pass = 0;
    int per = 0, ph = 0, burst_left = 0, ph_b = 0;
    int comp_bad = 0;

    pll_lock_monitor dut (
        .clk_in(clk), .reset(reset), .tog_async(tog),
        .locked(locked), .rst_out(rst_out), .edge_count(edge_count),
        .window_done(window_done), .fault_sticky(fault_sticky)
    );

    pll_lock_monitor #(.WINDOW(64), .CNT_W(4)) dut_sat (
        .clk_in(clk), .reset(reset), .tog_async(tog_b),
        .locked(locked_b), .rst_out(rst_out_b), .edge_count(edge_count_b),
        .window_done(window_done_b), .fault_sticky(fault_sticky_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    endtask

    // One clock: sample at negedge, then advance the toggle generators.
    task automatic tick();
        @(negedge clk);
        if (rst_out !== ~locked || rst_out_b !== ~locked_b) comp_bad++;
        if (burst_left > 0) begin
            ph++;
            if (ph >= 2) begin ph = 0; tog = ~tog; burst_left--; end
        end else if (per > 0) begin
            ph++;
            if (ph >= per) begin ph = 0; tog = ~tog; end
        end
        ph_b++;
        if (ph_b >= 2) begin ph_b = 0; tog_b = ~tog_b; end
    endtask

    task automatic wait_wd(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            tick();
            if (window_done === 1'b1) begin ok = 1'b1; break; end
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1; per = 0; ph = 0; burst_left = 0; tog = 1'b0;
        repeat (3) tick();
        chk({tag, "_locked"}, 32'(locked), 32'd0);
        chk({tag, "_rst_out"}, 32'(rst_out), 32'd1);
        chk({tag, "_edge_count"}, 32'(edge_count), 32'd0);
        chk({tag, "_window_done"}, 32'(window_done), 32'd0);
        chk({tag, "_fault"}, 32'(fault_sticky), 32'd0);
    endtask

    // Release reset, then expect lock exactly 5 windows later.
    task automatic lock_from_release(input string tag);
        int wd_bad, ec_bad;
        wd_bad = 0; ec_bad = 0;
        reset = 1'b0;
        for (int k = 1; k <= 5120; k++) begin
            tick();
            if ((window_done === 1'b1) != (k % 1024 == 0)) wd_bad++;
            if (window_done === 1'b1 && k > 1024 && edge_count !== 16'd128) ec_bad++;
            if (k == 5119) chk({tag, "_prelock"}, 32'(locked), 32'd0);
        end
        chk({tag, "_locked"}, 32'(locked), 32'd1);
        chk({tag, "_rst_out"}, 32'(rst_out), 32'd0);
        chk({tag, "_wd_at_lock"}, 32'(window_done), 32'd1);
        chk({tag, "_count"}, 32'(edge_count), 32'd128);
        chk({tag, "_wd_period"}, 32'(wd_bad), 32'd0);
        chk({tag, "_counts"}, 32'(ec_bad), 32'd0);
    endtask

    initial begin
        int lock_seen, rng_bad;
        int bn[11];
        logic [31:0] bl[11];
        reset = 1'b1; tog = 1'b0; tog_b = 1'b0;

        // Nominal lock, toggle every 8 cycles -> 128 edges per window
        do_reset("rst1");
        per = 8; ph = 0;
        lock_from_release("nom");

        // Loss of lock: hold the toggle, then resume and relock
        per = 0;
        wait_wd("loss_wd");
        chk("loss_low", 32'(edge_count < 16'd120), 32'd1);
        chk("loss_locked", 32'(locked), 32'd0);
        chk("loss_rst_out", 32'(rst_out), 32'd1);
        chk("loss_fault", 32'(fault_sticky), FAULT_EXP);
        per = 8; ph = 0;
        wait_wd("re_wd1");
        wait_wd("re_wd2");
        wait_wd("re_wd3");
        chk("re_prelock", 32'(locked), 32'd0);
        wait_wd("re_wd4");
        chk("re_locked", 32'(locked), 32'd1);
        chk("re_fault", 32'(fault_sticky), FAULT_EXP);

        // Slow clock: toggle every 10 cycles -> 102/103 edges, never lock
        do_reset("rst2");
        per = 10; ph = 0; reset = 1'b0;
        lock_seen = 0; rng_bad = 0;
        for (int w = 0; w < 20; w++) begin
            wait_wd("slow_wd");
            if (locked !== 1'b0) lock_seen++;
            if (w > 0 && (edge_count < 16'd102 || edge_count > 16'd103)) rng_bad++;
        end
        chk("slow_lock_seen", 32'(lock_seen), 32'd0);
        chk("slow_range", 32'(rng_bad), 32'd0);
        chk("slow_rst_out", 32'(rst_out), 32'd1);

        // Range boundaries: exact edge bursts, one per window
        bn = '{136, 120, 119, 120, 136, 120, 137, 120, 136, 120, 136};
        bl = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        do_reset("rst3");
        reset = 1'b0;
        wait_wd("bnd_flush");
        for (int i = 0; i < 11; i++) begin
            burst_left = bn[i]; ph = 0;
            wait_wd("bnd_wd");
            chk($sformatf("bnd%0d_count", i), 32'(edge_count), 32'(bn[i]));
            chk($sformatf("bnd%0d_locked", i), 32'(locked), bl[i]);
        end

        // Reset pulse in the third ACQUIRE window, then full re-acquisition
        do_reset("rst4");
        per = 8; ph = 0; reset = 1'b0;
        wait_wd("mid_wd1");
        wait_wd("mid_wd2");
        wait_wd("mid_wd3");
        repeat (500) tick();
        chk("mid_count_before", 32'(edge_count), 32'd128);
        reset = 1'b1;
        tick();
        chk("mid_locked", 32'(locked), 32'd0);
        chk("mid_rst_out", 32'(rst_out), 32'd1);
        chk("mid_edge_count", 32'(edge_count), 32'd0);
        chk("mid_window_done", 32'(window_done), 32'd0);
        lock_from_release("mid");

        // Saturation on the CNT_W=4 instance: 32 edges per window clamp to 15
        begin
            bit ok;
            ok = 1'b0;
            for (int i = 0; i < 200; i++) begin
                tick();
                if (window_done_b === 1'b1) begin ok = 1'b1; break; end
            end
            chk("sat_wd", 32'(ok), 32'd1);
        end
        chk("sat_count", 32'(edge_count_b), 32'd15);
        chk("sat_locked", 32'(locked_b), 32'd0);
        chk("sat_rst_out", 32'(rst_out_b), 32'd1);
        chk("sat_fault", 32'(fault_sticky_b), 32'd0);

        chk("complement", 32'(comp_bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
